// File: rtl/wb_reg_slave_pkg.sv
// wb_reg_slave_pkg: shared types and sizing helpers for the Wishbone register slave.
package wb_reg_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait counter is wide enough for 0..15 wait states.
  localparam int WCNT_W = 4;

  // Width of the word index into the register bank.
  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/wb_reg_slave_bank.sv
// wb_reg_slave_bank: control/status register array, write commit and read mux.
// Slot 0 is not stored; the live status input stands in for it on reads and
// on the flat view.
module wb_reg_slave_bank
  import wb_reg_slave_pkg::*;
#(
  parameter int pDataWidth = 32,
  parameter int pNumRegs   = 8,
  parameter int pIdxWidth  = idx_width(pNumRegs)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           commit,
  input  logic                           wr_en,
  input  logic                           in_range,
  input  logic [pIdxWidth-1:0]           idx,
  input  logic [pDataWidth-1:0]          wr_data,
  input  logic [pDataWidth-1:0]          status,
  output logic [pDataWidth-1:0]          rd_data,
  output logic [pNumRegs*pDataWidth-1:0] reg_flat,
  output logic                           wr_hit
);

  logic [pDataWidth-1:0] regs [1:pNumRegs-1];

  // A write only lands on an in-range, non-status slot of a committed access.
  assign wr_hit = commit & wr_en & in_range & (idx != '0);

  // Register storage; slot selected by comparison so index 0 never aliases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < pNumRegs; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < pNumRegs; i++)
        if (wr_hit && idx == pIdxWidth'(i)) regs[i] <= wr_data;
    end
  end

  // Read mux: out-of-range reads return zero, slot 0 returns live status.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (idx == '0) rd_data = status;
      for (int i = 1; i < pNumRegs; i++)
        if (idx == pIdxWidth'(i)) rd_data = regs[i];
    end
  end

  assign reg_flat[0 +: pDataWidth] = status;
  for (genvar g = 1; g < pNumRegs; g++) begin : g_flat
    assign reg_flat[g*pDataWidth +: pDataWidth] = regs[g];
  end

endmodule

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone (classic/pipelined) slave fronting a small register
// bank. One access outstanding; pWaitStates cycles between accept and the
// response cycle, then a registered one-cycle o_Ack/o_Rty.
// Optional feature: define WB_REG_SLAVE_RETRY_EN to add i_Busy and o_Rty.
module wb_reg_slave
  import wb_reg_slave_pkg::*;
#(
  parameter int pAddrWidth  = 32,
  parameter int pDataWidth  = 32,
  parameter int pNumRegs    = 8,
  parameter int pWaitStates = 1
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_WbCyc,
  input  logic                           i_WbStb,
  input  logic                           i_WbWEn,
  input  logic [pAddrWidth-1:0]          iv_WbAddr,
  input  logic [pDataWidth-1:0]          iv_WbWrData,
  output logic [pDataWidth-1:0]          ov_WbRdData,
  output logic                           o_Ack,
  output logic                           o_Stall,
  output logic                           o_Rty,
`ifdef WB_REG_SLAVE_RETRY_EN
  input  logic                           i_Busy,
`endif
  input  logic [pDataWidth-1:0]          iv_Status,
  output logic [pNumRegs*pDataWidth-1:0] ov_RegFlat,
  output logic                           o_WrStrobe,
  output logic [3:0]                     ov_WrIdx
);

  localparam int IW = idx_width(pNumRegs);

  state_e                state, next_state;
  logic                  accept, resp, stall;
  logic [WCNT_W-1:0]     cnt;
  logic [IW-1:0]         idx_q;
  logic                  in_range_q, we_q, busy_in, busy_q, wr_hit;
  logic [pDataWidth-1:0] wdata_q, bank_rd;
  logic                  addr_unused;

  // Byte-lane bits carry no meaning for word registers.
  assign addr_unused = ^iv_WbAddr[1:0];

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and handshake outputs. RESP ignores the strobe so a master
  // still holding it cannot be accepted twice.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    resp       = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: if (i_WbCyc && i_WbStb) begin
        accept     = 1'b1;
        next_state = (pWaitStates == 0) ? RESP : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (!i_WbCyc)                   next_state = IDLE;
        else if (cnt == WCNT_W'(1))     next_state = RESP;
      end
      RESP: begin
        stall      = 1'b1;
        resp       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_Stall = stall;

  // Request capture, wait countdown and busy sample on the edge entering RESP.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt        <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= WCNT_W'(pWaitStates);
        idx_q      <= iv_WbAddr[IW+1:2];
        in_range_q <= (iv_WbAddr[pAddrWidth-1:IW+2] == '0);
        we_q       <= i_WbWEn;
        wdata_q    <= iv_WbWrData;
      end else if (state == WAIT) begin
        cnt <= cnt - WCNT_W'(1);
      end
      if (next_state == RESP && state != RESP) busy_q <= busy_in;
    end
  end

  // Response pulse; read data is forced to zero outside the ack cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Ack       <= 1'b0;
      ov_WbRdData <= '0;
      o_WrStrobe  <= 1'b0;
      ov_WrIdx    <= '0;
    end else begin
      o_Ack       <= resp & ~busy_q;
      ov_WbRdData <= (resp && !busy_q && !we_q) ? bank_rd : '0;
      o_WrStrobe  <= wr_hit;
      if (wr_hit) ov_WrIdx <= 4'(idx_q);
    end
  end

`ifdef WB_REG_SLAVE_RETRY_EN
  logic rty_q;

  assign busy_in = i_Busy;

  // Retry pulse replaces the ack when the application was busy.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) rty_q <= 1'b0;
    else       rty_q <= resp & busy_q;
  end

  assign o_Rty = rty_q;
`else
  assign busy_in = 1'b0;
  assign o_Rty   = 1'b0;
`endif

  wb_reg_slave_bank #(
    .pDataWidth (pDataWidth),
    .pNumRegs   (pNumRegs),
    .pIdxWidth  (IW)
  ) u_bank (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .commit   (resp & ~busy_q),
    .wr_en    (we_q),
    .in_range (in_range_q),
    .idx      (idx_q),
    .wr_data  (wdata_q),
    .status   (iv_Status),
    .rd_data  (bank_rd),
    .reg_flat (ov_RegFlat),
    .wr_hit   (wr_hit)
  );

endmodule

// File: tb/tb_wb_reg_slave.sv
// tb_wb_reg_slave: scoreboard bench; two slaves (1 and 3 wait states) driven
// one at a time. Expected responses are queued at accept and matched when
// o_Ack/o_Rty appears; a reference register model tracks ov_RegFlat.
module tb_wb_reg_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int WS [2] = '{1, 3};
  localparam logic [31:0] STATUS = 32'h5A5A0001;
`ifdef WB_REG_SLAVE_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    int          d;
    int          cyc;
    logic        rty;
    logic [31:0] rd;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]           rst, cyc, stb, we, busy, ack, stall, rty, wstrb;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][DW-1:0]   wdata, rdata;
  logic [1:0][3:0]      widx;
  logic [1:0][NR*DW-1:0] flat;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  exp_t sb[$];
  logic [31:0] mdl [2][NR];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_reg_slave #(
      .pAddrWidth(AW), .pDataWidth(DW), .pNumRegs(NR), .pWaitStates(WS[g])
    ) dut (
      .i_Clk(clk), .i_Rst(rst[g]), .i_WbCyc(cyc[g]), .i_WbStb(stb[g]),
      .i_WbWEn(we[g]), .iv_WbAddr(addr[g]), .iv_WbWrData(wdata[g]),
      .ov_WbRdData(rdata[g]), .o_Ack(ack[g]), .o_Stall(stall[g]), .o_Rty(rty[g]),
`ifdef WB_REG_SLAVE_RETRY_EN
      .i_Busy(busy[g]),
`endif
      .iv_Status(STATUS), .ov_RegFlat(flat[g]), .o_WrStrobe(wstrb[g]),
      .ov_WrIdx(widx[g])
    );
  end

  task automatic chk(string tag, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat(int d);
    logic [255:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = (i == 0) ? STATUS : mdl[d][i];
    return f;
  endfunction

  function automatic exp_t predict(int d, logic w, logic [31:0] a, logic [31:0] wd, int k);
    exp_t e;
    logic oor = |a[31:5];
    logic b   = RETRY ? busy[d] : 1'b0;
    e.d   = d;
    e.cyc = k + WS[d] + 1;
    e.rty = b;
    e.idx = a[4:2];
    e.wd  = wd;
    e.wr  = w && !b && !oor && (e.idx != 3'd0);
    e.rd  = (w || b || oor) ? 32'h0 : ((e.idx == 3'd0) ? STATUS : mdl[d][e.idx]);
    return e;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: match responses against the scoreboard, track the model.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        for (int i = 0; i < NR; i++) mdl[d][i] = 32'h0;
        continue;
      end
      if (ack[d] || rty[d]) begin
        if (sb.size() == 0 || sb[0].d != d) begin
          chk($sformatf("unexp_resp%0d", d), {ack[d], rty[d]}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk($sformatf("resp_cyc%0d", d), cyc_n, e.cyc);
          chk($sformatf("ack%0d", d), ack[d], !e.rty);
          chk($sformatf("rty%0d", d), rty[d], e.rty);
          chk($sformatf("rdata%0d", d), rdata[d], e.rd);
          chk($sformatf("wstrb%0d", d), wstrb[d], e.wr);
          if (e.wr) begin
            chk($sformatf("widx%0d", d), widx[d], e.idx);
            mdl[d][e.idx] = e.wd;
          end
        end
      end else begin
        chk($sformatf("rd_idle%0d", d), rdata[d], 0);
        chk($sformatf("wstrb_idle%0d", d), wstrb[d], 0);
      end
      chk($sformatf("flat%0d", d), flat[d], model_flat(d));
    end
  end

  // Raise a request and hold it until accepted; optionally queue the response.
  task automatic start(int d, logic w, logic [31:0] a, logic [31:0] wd, bit push, output int k);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    k = -1;
    for (int t = 0; t < 50 && k < 0; t++) begin
      @(negedge clk);
      if (!stall[d]) begin
        k = cyc_n + 1;
        if (push) sb.push_back(predict(d, w, a, wd, k));
      end
      @(posedge clk); #1;
    end
    if (k < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(int d);
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 0, 1);
      sb.delete();
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic acc(int d, logic w, logic [31:0] a, logic [31:0] wd);
    int k;
    start(d, w, a, wd, 1'b1, k);
    stb[d] = 1'b0;
    drain(d);
  endtask

  task automatic chk_rst(int d, string t);
    chk({t, "_ack"},   ack[d],   0);
    chk({t, "_rty"},   rty[d],   0);
    chk({t, "_stall"}, stall[d], 0);
    chk({t, "_wstrb"}, wstrb[d], 0);
    chk({t, "_rdata"}, rdata[d], 0);
    chk({t, "_widx"},  widx[d],  0);
  endtask

  initial begin
    int k1, k2;
    rst = 2'b11; cyc = '0; stb = '0; we = '0; busy = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    chk_rst(0, "rst0");
    chk_rst(1, "rst1");

    // Basic write/read on the 1-wait-state slave.
    acc(0, 1'b1, 32'h04, 32'hDEADBEEF);
    acc(0, 1'b0, 32'h04, 32'h0);
    acc(0, 1'b0, 32'h00, 32'h0);
    // Writes to status slot and out of range: acked, no change, no strobe.
    acc(0, 1'b1, 32'h00,  32'h12345678);
    acc(0, 1'b1, 32'h100, 32'h12345678);
    acc(0, 1'b0, 32'h104, 32'h0);
    acc(0, 1'b1, 32'h1C,  32'hA5A5_0F0F);
    acc(0, 1'b0, 32'h1F,  32'h0);

    // Abort by dropping cyc mid-WAIT.
    start(0, 1'b1, 32'h08, 32'hFFFFFFFF, 1'b0, k1);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("abort_stall", stall[0], 0);
    acc(0, 1'b0, 32'h08, 32'h0);

    // Abort by reset mid-WAIT: everything returns to reset values.
    start(0, 1'b1, 32'h08, 32'hFFFFFFFF, 1'b0, k1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    chk_rst(0, "midrst");
    repeat (4) @(posedge clk); #1;
    chk_rst(0, "postrst");

`ifdef WB_REG_SLAVE_RETRY_EN
    busy[0] = 1'b1;
    acc(0, 1'b1, 32'h0C, 32'h0000CAFE);
    busy[0] = 1'b0;
    acc(0, 1'b1, 32'h0C, 32'h0000CAFE);
    acc(0, 1'b0, 32'h0C, 32'h0);
`endif

    // Pipelined master on the 3-wait-state slave: strobe held across two writes.
    start(1, 1'b1, 32'h08, 32'h11111111, 1'b1, k1);
    start(1, 1'b1, 32'h0C, 32'h22222222, 1'b1, k2);
    chk("pipe_gap", k2 - k1, 5);
    stb[1] = 1'b0;
    drain(1);
    acc(1, 1'b0, 32'h08, 32'h0);
    acc(1, 1'b0, 32'h0C, 32'h0);
    acc(1, 1'b1, 32'h04, 32'h0BADF00D);
    acc(1, 1'b0, 32'h04, 32'h0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_slave.md
# wb_reg_slave

Wishbone slave sitting directly downstream of the team's Wishbone master model. It accepts single or pipelined-mode cycles, adds a programmable number of wait states, and answers each access with exactly one o_Ack (or o_Rty) pulse. It fronts a small control/status register bank used by SGMII bench and RTL blocks. One transaction is outstanding at a time, with back-pressure through o_Stall.

## Interface
- pAddrWidth, 32, address bus width
- pDataWidth, 32, data bus width
- pNumRegs, 8, number of 32-bit word registers (power of 2, 2..16); index 0 is read-only status
- pWaitStates, 1, cycles inserted between accept and response (0..15)

- i_Clk  in  1  single clock, all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_WbCyc  in  1  cycle valid
- i_WbStb  in  1  strobe
- i_WbWEn  in  1  1 = write, 0 = read
- iv_WbAddr  in  pAddrWidth  byte address, word-aligned
- iv_WbWrData  in  pDataWidth  write data
- ov_WbRdData  out  pDataWidth  read data, valid only while o_Ack=1, else 0
- o_Ack  out  1  one-cycle acknowledge
- o_Stall  out  1  request not accepted this cycle
- o_Rty  out  1  one-cycle retry response (macro-dependent)
- i_Busy  in  1  application busy, forces retry (macro-dependent)
- iv_Status  in  pDataWidth  value returned for register 0
- ov_RegFlat  out  pNumRegs*pDataWidth  all registers, reg i at bits [i*pDataWidth +: pDataWidth]; slice 0 mirrors iv_Status
- o_WrStrobe  out  1  one-cycle pulse when a register write commits
- ov_WrIdx  out  4  index of the committed write

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: o_Stall=0. An access is accepted on an edge that samples i_WbCyc & i_WbStb = 1. Accept latches the address index, the write data and i_WbWEn, and loads the wait counter with pWaitStates. Next state is WAIT, or RESP if pWaitStates=0.
- WAIT: o_Stall=1. The counter decrements each edge. When the counter reaches 1, the FSM moves to RESP. If i_WbCyc=0 at any WAIT edge, the access aborts: IDLE, no write, no response.
- Entering RESP:
  - If busy, o_Rty=1 and no write.
  - Otherwise o_Ack=1.
  - For a write: registers 1..pNumRegs-1 update, o_WrStrobe=1, ov_WrIdx=index.
  - For a read: ov_WbRdData = register contents.
- RESP: o_Stall=1; lasts exactly one cycle, then IDLE. i_WbStb is ignored in RESP, so the master's held strobe cannot be re-accepted.
- Index = iv_WbAddr[clog2(pNumRegs)+1:2]. If any higher address bit is nonzero, the address is out of range: reads return 0, writes are dropped, o_WrStrobe stays 0, and the access is still acked. Writes to index 0 are dropped but acked.
- Address bits [1:0] are ignored.

## Timing
- Reset values:
  - FSM = IDLE
  - o_Ack=0, o_Rty=0, o_Stall=0, o_WrStrobe=0
  - ov_WbRdData=0, ov_WrIdx=0
  - registers 1..N-1 = 0
- Accept at edge k. o_Ack/o_Rty are high from edge k+pWaitStates+1 to k+pWaitStates+2. Read data is valid in the same cycle.
- A write is visible on ov_RegFlat from the edge that raises o_Ack.
- The next accept is possible at edge k+pWaitStates+2. Throughput is one access per pWaitStates+2 cycles.
- If i_Rst is asserted mid-transaction, the access is discarded at that edge, with no write and no response.

## Configuration
- WB_REG_SLAVE_RETRY_EN defined:
  - i_Busy port exists and is sampled at the edge entering RESP.
  - i_Busy=1 gives o_Rty=1, o_Ack=0, no write, no o_WrStrobe.
- Undefined:
  - i_Busy port is absent and o_Rty is tied 0.
  - Every access completes with o_Ack.

## Structure
- Package wb_reg_slave_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - wait-counter width constant (4 bits)
  - index width localparam function
- Sub-module wb_reg_slave_bank holds the register array, write commit and read mux. The FSM and wait counter stay in the top level.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with pWaitStates=1 -> o_Ack high exactly 2 cycles after accept; reg1 = 0xDEADBEEF; o_WrStrobe pulse with ov_WrIdx=1.
- Read 0x04, then read 0x00 with iv_Status=0x5A5A0001 -> returns 0xDEADBEEF, then 0x5A5A0001; ov_WbRdData=0 outside the ack cycles.
- Write 0x12345678 to 0x00 and to 0x100 -> both acked; reg0 still mirrors iv_Status; no register changes; no o_WrStrobe.
- pWaitStates=3, pipelined master holding i_WbStb for two back-to-back writes -> o_Stall high 4 cycles after each accept; acks 5 cycles apart; both registers written.
- i_WbCyc dropped during WAIT of a write of 0xFFFFFFFF to 0x08 -> no ack, reg2 unchanged, FSM in IDLE. Repeat with i_Rst pulsed mid-WAIT -> same result, all outputs at reset values.
- With WB_REG_SLAVE_RETRY_EN and i_Busy=1, write 0x0000CAFE to 0x0C -> o_Rty one cycle, o_Ack=0, reg3 unchanged. Retry with i_Busy=0 -> o_Ack, reg3 = 0x0000CAFE.
